// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side drain engine for the fifo block. Pops words from a
// first-word-fall-through FIFO read port and presents them on a
// valid/ready streaming master interface. A two-entry output buffer
// (head + skid) lets the pop strobe depend only on registered state.
// This keeps rd_o free of any combinational path from m_ready_i while
// still sustaining one word per cycle.
//
// Ports:
//   clk_i      - clock, all state updates on the rising edge
//   rst_i      - synchronous active-high reset
//   empty_i    - FIFO empty flag
//   r_data_i   - FIFO head word, valid whenever empty_i=0
//   rd_o       - FIFO pop strobe, head removed at the edge where rd_o=1
//   flush_i    - discard all buffered words
//   m_valid_o  - stream word valid
//   m_ready_i  - downstream ready
//   m_data_o   - stream word
//   xfer_cnt_o - count of completed stream transfers (wraps)

module fifo_rd_stream #(
  parameter int WordLength = 8,
  parameter int CntBits    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  empty_i,
  input  logic [WordLength-1:0] r_data_i,
  output logic                  rd_o,
  input  logic                  flush_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [WordLength-1:0] m_data_o,
  output logic [CntBits-1:0]    xfer_cnt_o
);

  // EMPTY: no word buffered, ONE: head valid, TWO: head and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CntBits-1:0] CntOne = CntBits'(1);

  state_t                r_state;
  state_t                w_stateNext;
  logic [WordLength-1:0] r_head;
  logic [WordLength-1:0] w_headNext;
  logic [WordLength-1:0] r_skid;
  logic [WordLength-1:0] w_skidNext;
  logic [CntBits-1:0]    r_cnt;
  logic                  w_pop;
  logic                  w_cons;

  // The pop decision uses only registered state plus the FIFO flag and
  // the flush/reset controls. Refusing to pop in TWO bounds the words
  // taken during backpressure to the two buffer slots.
  assign w_pop  = ~empty_i & (r_state != TWO) & ~flush_i & ~rst_i;
  assign w_cons = m_valid_o & m_ready_i;

  assign rd_o       = w_pop;
  assign m_valid_o  = (r_state != EMPTY);
  assign m_data_o   = r_head;
  assign xfer_cnt_o = r_cnt;

  // Next-state and buffer-load decisions. A flush wins over any pop or
  // consume. The head keeps its old value, so m_data_o holds the last
  // word once the buffer drains or is flushed.
  always_comb begin
    w_stateNext = r_state;
    w_headNext  = r_head;
    w_skidNext  = r_skid;
    if (flush_i) begin
      w_stateNext = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_pop) begin
            w_stateNext = ONE;
            w_headNext  = r_data_i;
          end
        end
        ONE: begin
          if (w_pop && w_cons) begin
            w_headNext = r_data_i;
          end else if (w_pop) begin
            w_stateNext = TWO;
            w_skidNext  = r_data_i;
          end else if (w_cons) begin
            w_stateNext = EMPTY;
          end
        end
        TWO: begin
          if (w_cons) begin
            w_stateNext = ONE;
            w_headNext  = r_skid;
          end
        end
        default: begin
          w_stateNext = EMPTY;
        end
      endcase
    end
  end

  // State and buffer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_head  <= w_headNext;
      r_skid  <= w_skidNext;
    end
  end

  // Transfer counter. A transfer that coincides with a flush still
  // counts. Flush never clears the counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_cons) begin
      r_cnt <= r_cnt + CntOne;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream. The FIFO is a bench-side queue that
// reacts to rd_o. A queue-based model of the output buffer predicts
// rd_o, m_valid_o, m_data_o and xfer_cnt_o every cycle. Consumed words
// are logged with their cycle number so ordering and gap-free streaming
// can be checked against hand-written sequences.

module tb_fifo_rd_stream;

  localparam int W  = 8;
  localparam int CB = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          empty_i;
  logic [W-1:0]  r_data_i;
  logic          rd_o;
  logic          flush_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [W-1:0]  m_data_o;
  logic [CB-1:0] xfer_cnt_o;

  always #5 clk_i = ~clk_i;

  fifo_rd_stream #(
    .WordLength(W),
    .CntBits(CB)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .empty_i(empty_i),
    .r_data_i(r_data_i),
    .rd_o(rd_o),
    .flush_i(flush_i),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_data_o(m_data_o),
    .xfer_cnt_o(xfer_cnt_o)
  );

  // Bench FIFO contents, front = head word
  logic [W-1:0] fifoQ[$];
  // Model: words held by the streaming engine, front = current output
  logic [W-1:0] mBuf[$];
  logic [W-1:0] mLast;
  int           mCnt;
  logic         modelKnown;
  // Consumed words and the cycle each was consumed in
  logic [W-1:0] outLog[$];
  int           outCyc[$];
  int           cycNum;

  int passCount  = 0;
  int checkCount = 0;

  // Compare one value and report on mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock cycle: drive inputs, compare against the model at the
  // falling edge, advance model and FIFO across the rising edge
  task automatic applyStimulus(input logic rst, input logic flush, input logic ready);
    logic expRd;
    logic cons;
    logic sawRd;
    rst_i     = rst;
    flush_i   = flush;
    m_ready_i = ready;
    empty_i   = (fifoQ.size() == 0);
    r_data_i  = (fifoQ.size() == 0) ? '0 : fifoQ[0];
    @(negedge clk_i);
    expRd = (fifoQ.size() != 0) && (mBuf.size() < 2) && !flush && !rst;
    checkOutput("rd_o", 32'(rd_o), 32'(expRd));
    if (modelKnown) begin
      checkOutput("m_valid_o", 32'(m_valid_o), 32'(mBuf.size() > 0));
      checkOutput("m_data_o", 32'(m_data_o), 32'((mBuf.size() > 0) ? mBuf[0] : mLast));
      checkOutput("xfer_cnt_o", 32'(xfer_cnt_o), 32'(mCnt % 16));
    end
    sawRd = rd_o;
    cons  = (mBuf.size() > 0) && ready;
    if (rst) begin
      mBuf.delete();
      mLast      = '0;
      mCnt       = 0;
      modelKnown = 1'b1;
    end else begin
      if (cons) begin
        mCnt++;
        outLog.push_back(mBuf[0]);
        outCyc.push_back(cycNum);
      end
      if (flush) begin
        mBuf.delete();
      end else begin
        if (cons) void'(mBuf.pop_front());
        if (expRd) mBuf.push_back(fifoQ[0]);
      end
      if (mBuf.size() > 0) mLast = mBuf[0];
    end
    @(posedge clk_i);
    #1;
    if (sawRd && fifoQ.size() > 0) void'(fifoQ.pop_front());
    cycNum++;
  endtask

  // Check logged words from index startIdx match exp, consumed on
  // consecutive cycles when gapless is set
  task automatic checkLog(input string name, input int startIdx, input logic [W-1:0] exp[$],
                          input bit gapless);
    checkOutput({name, "_count"}, 32'(outLog.size() - startIdx), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (startIdx + i < outLog.size()) begin
        checkOutput({name, "_word"}, 32'(outLog[startIdx + i]), 32'(exp[i]));
        if (gapless && i > 0)
          checkOutput({name, "_gap"}, 32'(outCyc[startIdx + i] - outCyc[startIdx + i - 1]), 32'd1);
      end
    end
  endtask

  initial begin
    int            base;
    logic [W-1:0]  expSeq[$];
    rst_i      = 1'b1;
    flush_i    = 1'b0;
    m_ready_i  = 1'b1;
    empty_i    = 1'b1;
    r_data_i   = '0;
    modelKnown = 1'b0;
    mLast      = '0;
    mCnt       = 0;
    cycNum     = 0;

    // Reset with three words waiting: nothing may be popped
    fifoQ = '{8'h31, 8'h32, 8'h33};
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("rst_valid", 32'(m_valid_o), 32'd0);
    checkOutput("rst_data", 32'(m_data_o), 32'd0);
    checkOutput("rst_cnt", 32'(xfer_cnt_o), 32'd0);
    checkOutput("rst_fifo_kept", 32'(fifoQ.size()), 32'd3);
    fifoQ.delete();
    applyStimulus(1'b1, 1'b0, 1'b1);

    // Single word
    fifoQ.push_back(8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("single_valid", 32'(m_valid_o), 32'd1);
    checkOutput("single_data", 32'(m_data_o), 32'hA5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("single_done_valid", 32'(m_valid_o), 32'd0);
    checkOutput("single_cnt", 32'(xfer_cnt_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("single_hold_data", 32'(m_data_o), 32'hA5);

    // Throughput: four words back to back
    base = outLog.size();
    fifoQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    expSeq = '{8'h01, 8'h02, 8'h03, 8'h04};
    checkLog("thru", base, expSeq, 1'b1);
    checkOutput("thru_cnt", 32'(xfer_cnt_o), 32'd5);

    // Backpressure: only two words taken while stalled
    base = outLog.size();
    fifoQ = '{8'h10, 8'h11, 8'h12, 8'h13};
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp_fifo_left", 32'(fifoQ.size()), 32'd2);
    checkOutput("bp_hold_data", 32'(m_data_o), 32'h10);
    checkOutput("bp_hold_valid", 32'(m_valid_o), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    expSeq = '{8'h10, 8'h11, 8'h12, 8'h13};
    checkLog("bp", base, expSeq, 1'b1);
    checkOutput("bp_cnt", 32'(xfer_cnt_o), 32'd9);

    // Flush while holding two words
    base = outLog.size();
    fifoQ = '{8'h20, 8'h21, 8'h22};
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fl_fifo_left", 32'(fifoQ.size()), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("fl_valid", 32'(m_valid_o), 32'd0);
    checkOutput("fl_cnt", 32'(xfer_cnt_o), 32'd9);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    expSeq = '{8'h22};
    checkLog("fl", base, expSeq, 1'b0);
    checkOutput("fl_cnt_after", 32'(xfer_cnt_o), 32'd10);

    // Flush coinciding with a transfer still counts it
    fifoQ = '{8'h55, 8'h56};
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("flcons_cnt", 32'(xfer_cnt_o), 32'd11);
    checkOutput("flcons_valid", 32'(m_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);

    // Counter wrap with a 4-bit counter: 17 transfers after reset
    fifoQ.delete();
    applyStimulus(1'b1, 1'b0, 1'b1);
    base = outLog.size();
    for (int i = 0; i < 17; i++) fifoQ.push_back(W'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (outLog.size() - base == 15) checkOutput("wrap_15", 32'(xfer_cnt_o), 32'd15);
      if (outLog.size() - base == 16) checkOutput("wrap_16", 32'(xfer_cnt_o), 32'd0);
      if (outLog.size() - base == 17) checkOutput("wrap_17", 32'(xfer_cnt_o), 32'd1);
    end
    checkOutput("wrap_total", 32'(outLog.size() - base), 32'd17);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for the fifo block. Pops words from the FIFO read port and presents them on a valid/ready streaming master interface.
- Contains a 2-entry output buffer (head + skid), so rd_o never depends combinationally on m_ready_i and a full word per cycle is sustained.
- Sits between the fifo instance (r_data_o, empty_o, rd_i) and any downstream consumer.

Parameters:
- WordLength, 8, data width in bits; matches the fifo WordLength.
- CntBits, 16, width of the transfer counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- empty_i  input  1  FIFO empty flag (fifo empty_o).
- r_data_i  input  WordLength  FIFO head word (fifo r_data_o); valid whenever empty_i=0 (first-word-fall-through).
- rd_o  output  1  FIFO pop strobe (fifo rd_i); head removed at the clock edge where rd_o=1.
- flush_i  input  1  discard all buffered words.
- m_valid_o  output  1  stream word valid.
- m_ready_i  input  1  downstream ready.
- m_data_o  output  WordLength  stream word.
- xfer_cnt_o  output  CntBits  count of completed stream transfers.

Behaviour:
- Definitions:
  - pop = rd_o.
  - cons = m_valid_o & m_ready_i.
  - rd_o = ~empty_i & (state != TWO) & ~flush_i & ~rst_i. Combinational from registered state and empty_i only.
- Reset (rst_i=1 at edge):
  - state=EMPTY, m_valid_o=0, m_data_o=0, skid=0, xfer_cnt_o=0.
  - rd_o=0 while rst_i=1.
- States: EMPTY (0 words), ONE (head valid), TWO (head+skid valid). m_valid_o=1 in ONE and TWO, registered.
- EMPTY:
  - pop: -> ONE, head<=r_data_i.
  - no pop: stay.
- ONE:
  - pop & cons: stay ONE, head<=r_data_i.
  - pop & ~cons: -> TWO, skid<=r_data_i.
  - ~pop & cons: -> EMPTY.
  - neither: stay.
- TWO (pop is always 0):
  - cons: -> ONE, head<=skid.
  - ~cons: stay.
- Latency: a word popped at edge N is on m_data_o with m_valid_o=1 after edge N (visible in cycle N+1).
- Throughput: with m_ready_i=1 and FIFO non-empty, one transfer per cycle in steady state (state ONE).
- Handshake rules:
  - While m_valid_o=1 & m_ready_i=0, m_data_o is stable.
  - m_valid_o drops only after cons, flush or reset.
  - Words leave in FIFO order; no loss, no duplication.
- Backpressure: at most 2 words popped while m_ready_i=0; rd_o=0 in TWO.
- Empty FIFO: rd_o=0; m_data_o holds its last value when returning to EMPTY.
- flush_i=1:
  - Next state EMPTY, skid discarded, rd_o=0 that cycle.
  - A cons coinciding with flush counts as a completed transfer.
  - xfer_cnt_o is not cleared.
  - Priority: rst_i > flush_i > normal operation.
- xfer_cnt_o:
  - +1 on every cons, registered.
  - Wraps 2^CntBits-1 -> 0; no saturation.
- Simultaneous empty_i deassert and cons in EMPTY: impossible (m_valid_o=0); pop only.
- Reset mid-stream: buffered words are lost; the FIFO is not popped during reset.

Test Plan:
- Reset: assert rst_i 2 cycles with FIFO holding 3 words -> m_valid_o=0, m_data_o=0, xfer_cnt_o=0, rd_o=0 throughout; FIFO still holds 3 words.
- Single word: write 0xA5, m_ready_i=1 -> rd_o=1 one cycle; next cycle m_valid_o=1, m_data_o=0xA5; after transfer m_valid_o=0, xfer_cnt_o=1.
- Throughput: FIFO holds 0x01..0x04, m_ready_i=1 -> 0x01..0x04 on consecutive cycles with m_valid_o continuous; xfer_cnt_o=4.
- Backpressure: FIFO holds 0x10..0x13, m_ready_i=0 -> exactly 2 pops, then rd_o=0; m_data_o=0x10 held. Raise m_ready_i -> output order 0x10, 0x11, 0x12, 0x13, no gaps after the first.
- Flush: state TWO holding 0x20/0x21, FIFO holds 0x22; pulse flush_i with m_ready_i=0 -> next cycle m_valid_o=0, then 0x22 is popped and output; 0x20/0x21 never appear; xfer_cnt_o unchanged.
- Counter wrap: CntBits=4, 17 transfers -> xfer_cnt_o reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
